// File: rtl/clic_pkg.sv
// Shared types and the level-decode helper for the CLIC interrupt arbiter.
package clic_pkg;

   // Candidate id width; covers NumSrc up to 256, widen for larger configurations.
   localparam int unsigned ClicIdW = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      KILL   = 2'd2
   } clic_arb_state_e;

   typedef struct packed {
      logic               found;
      logic [ClicIdW-1:0] id;
      logic [7:0]         ctl;
   } clic_cand_t;

   function automatic logic [7:0] clic_level(input logic [7:0] ctl, input logic [3:0] nlbits);
      logic [3:0] n;
      logic [7:0] mask;
      n    = (nlbits > 4'd8) ? 4'd8 : nlbits;
      mask = ~(8'hFF >> n);
      return (ctl & mask) | ~mask;
   endfunction

endpackage

// File: rtl/clic_max_tree.sv
// Combinational binary max-tree over CLIC candidates; ties resolve to the lowest index.
module clic_max_tree
   import clic_pkg::*;
#(
   parameter int unsigned N = 256
) (
   input  clic_cand_t cand_i [N],
   output clic_cand_t win_o
);

   localparam int unsigned Levels = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned Leaves = 1 << Levels;

   always_comb begin
      clic_cand_t nodes [2*Leaves-1];
      // Heap layout: node k has children 2k+1 (lower ids) and 2k+2.
      for (int i = 0; i < int'(Leaves); i++) begin
         if (i < int'(N)) begin
            nodes[int'(Leaves) - 1 + i] = cand_i[i];
         end else begin
            nodes[int'(Leaves) - 1 + i] = '0;
         end
      end
      for (int k = int'(Leaves) - 2; k >= 0; k--) begin
         if (nodes[2*k+1].found &&
             (!nodes[2*k+2].found || (nodes[2*k+1].ctl >= nodes[2*k+2].ctl))) begin
            nodes[k] = nodes[2*k+1];
         end else begin
            nodes[k] = nodes[2*k+2];
         end
      end
      win_o = nodes[0];
   end

endmodule

// File: rtl/clic_irq_arbiter.sv
// CLIC arbiter: picks the highest pending+enabled source and offers it to the hart with
// a valid/ready handshake, kill on preemption or withdrawal, and edge-pending clear on accept.
module clic_irq_arbiter
   import clic_pkg::*;
#(
   parameter int unsigned NumSrc         = 256,
   parameter int unsigned ClicIntCtlBits = 8,
   parameter int unsigned SrcW           = $clog2(NumSrc)
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic [NumSrc-1:0]           ip_i,
   input  logic [NumSrc-1:0]           ie_i,
   input  logic [NumSrc-1:0][7:0]      ctl_i,
   input  logic [NumSrc-1:0]           shv_i,
   input  logic [NumSrc-1:0]           edge_i,
   input  logic [NumSrc-1:0][1:0]      mode_i,
   input  logic [3:0]                  nlbits_i,
   input  logic [7:0]                  thresh_i,
   output logic                        irq_valid_o,
   input  logic                        irq_ready_i,
   output logic [SrcW-1:0]             irq_id_o,
   output logic [7:0]                  irq_level_o,
   output logic                        irq_shv_o,
   output logic [1:0]                  irq_priv_o,
   output logic                        irq_kill_req_o,
   input  logic                        irq_kill_ack_i,
   output logic [NumSrc-1:0]           ip_clr_o
);

   localparam int unsigned PadBits = 8 - ClicIntCtlBits;
   localparam logic [7:0]  CtlPad  = 8'((1 << PadBits) - 1);

   clic_cand_t      w_cand [NumSrc];
   clic_cand_t      w_win;
   clic_cand_t      r_s1;
   clic_arb_state_e r_state;
   clic_arb_state_e w_state_nxt;
   logic [SrcW-1:0] r_id;
   logic [7:0]      r_level;
   logic            r_shv;
   logic [1:0]      r_priv;
   logic [SrcW-1:0] w_s1_id;
   logic [7:0]      w_s1_level;
   logic            w_offer;
   logic            w_latch;
   logic            w_cur_live;
   logic            w_preempt;
   logic            w_accept;
   logic [NumSrc-1:0] w_clr;

   always_comb begin
      for (int i = 0; i < int'(NumSrc); i++) begin
         w_cand[i].found = ip_i[i] & ie_i[i];
         w_cand[i].id    = ClicIdW'(i);
         w_cand[i].ctl   = ctl_i[i] | CtlPad;
      end
   end

   clic_max_tree #(
      .N (NumSrc)
   ) u_max_tree (
      .cand_i (w_cand),
      .win_o  (w_win)
   );

   assign w_s1_id    = r_s1.id[SrcW-1:0];
   assign w_s1_level = clic_level(r_s1.ctl, nlbits_i);
   // Live ip/ie gate stops a just-cleared edge source, still stale in S1, from re-offering.
   assign w_offer    = r_s1.found && (w_s1_level > thresh_i) && ip_i[w_s1_id] && ie_i[w_s1_id];
   assign w_latch    = (r_state == IDLE) && w_offer;
   assign w_cur_live = ip_i[r_id] & ie_i[r_id];
   assign w_preempt  = r_s1.found && (w_s1_level > r_level);
   assign w_accept   = (r_state != IDLE) && irq_ready_i;

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (w_offer) w_state_nxt = ACCESS;
         ACCESS: begin
            if (irq_ready_i) begin
               w_state_nxt = IDLE;
            end else if (!w_cur_live || w_preempt || (r_level <= thresh_i)) begin
               w_state_nxt = KILL;
            end
         end
         KILL:    if (irq_ready_i || irq_kill_ack_i) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_clr = '0;
      if (w_accept && edge_i[r_id]) begin
         w_clr[r_id] = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= IDLE;
         r_s1    <= '0;
         r_id    <= '0;
         r_level <= '0;
         r_shv   <= 1'b0;
         r_priv  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_s1    <= w_win;
         if (w_latch) begin
            r_id    <= w_s1_id;
            r_level <= w_s1_level;
            r_shv   <= shv_i[w_s1_id];
            r_priv  <= mode_i[w_s1_id];
         end
      end
   end

   assign irq_valid_o    = (r_state != IDLE);
   assign irq_kill_req_o = (r_state == KILL);
   assign irq_id_o       = r_id;
   assign irq_level_o    = r_level;
   assign irq_shv_o      = r_shv;
   assign irq_priv_o     = r_priv;
   assign ip_clr_o       = w_clr;

endmodule
